// File: rtl/axil_wr_arb2.sv
// Two-port AXI-Lite write arbiter: round-robin share of one write master.
// Ports: clk, rst_n, s0_/s1_axil_* slaves, m_axil_* master, grant one-hot.
module axil_wr_arb2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
  input  logic [2:0]            s0_axil_awprot,
  input  logic                  s0_axil_awvalid,
  output logic                  s0_axil_awready,
  input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
  input  logic                  s0_axil_wvalid,
  output logic                  s0_axil_wready,
  output logic [1:0]            s0_axil_bresp,
  output logic                  s0_axil_bvalid,
  input  logic                  s0_axil_bready,

  input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
  input  logic [2:0]            s1_axil_awprot,
  input  logic                  s1_axil_awvalid,
  output logic                  s1_axil_awready,
  input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
  input  logic                  s1_axil_wvalid,
  output logic                  s1_axil_wready,
  output logic [1:0]            s1_axil_bresp,
  output logic                  s1_axil_bvalid,
  input  logic                  s1_axil_bready,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,

  output logic [1:0]            grant
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0] state;
  logic [1:0] grant_q;
  logic       last_q;
  logic       aw_done;
  logic       w_done;

  logic       req0;
  logic       req1;
  logic [1:0] pick;
  logic       sel;
  logic       in_xfer;
  logic       in_resp;
  logic       g_awvalid;
  logic       g_wvalid;
  logic       g_bready;
  logic       aw_fire;
  logic       w_fire;
  logic       b_fire;

  assign req0 = s0_axil_awvalid && s0_axil_wvalid;
  assign req1 = s1_axil_awvalid && s1_axil_wvalid;

  // last_q holds the port served last; on contention the other one wins.
  always_comb begin
    pick = 2'b00;
    if (req0 && req1) begin
      pick = last_q ? 2'b01 : 2'b10;
    end else if (req0) begin
      pick = 2'b01;
    end else if (req1) begin
      pick = 2'b10;
    end
  end

  assign sel     = grant_q[1];
  assign in_xfer = (state == S_XFER) && (grant_q != 2'b00);
  assign in_resp = (state == S_RESP) && (grant_q != 2'b00);

  assign g_awvalid = sel ? s1_axil_awvalid : s0_axil_awvalid;
  assign g_wvalid  = sel ? s1_axil_wvalid  : s0_axil_wvalid;
  assign g_bready  = sel ? s1_axil_bready  : s0_axil_bready;

  assign m_axil_awvalid = in_xfer && g_awvalid && !aw_done;
  assign m_axil_wvalid  = in_xfer && g_wvalid && !w_done;
  assign m_axil_bready  = in_resp && g_bready;

  // Payloads are forced to zero outside XFER.
  always_comb begin
    m_axil_awaddr = '0;
    m_axil_awprot = '0;
    m_axil_wdata  = '0;
    m_axil_wstrb  = '0;
    if (in_xfer) begin
      m_axil_awaddr = sel ? s1_axil_awaddr : s0_axil_awaddr;
      m_axil_awprot = sel ? s1_axil_awprot : s0_axil_awprot;
      m_axil_wdata  = sel ? s1_axil_wdata  : s0_axil_wdata;
      m_axil_wstrb  = sel ? s1_axil_wstrb  : s0_axil_wstrb;
    end
  end

  assign s0_axil_awready = in_xfer && grant_q[0] && m_axil_awready && !aw_done;
  assign s1_axil_awready = in_xfer && grant_q[1] && m_axil_awready && !aw_done;
  assign s0_axil_wready  = in_xfer && grant_q[0] && m_axil_wready && !w_done;
  assign s1_axil_wready  = in_xfer && grant_q[1] && m_axil_wready && !w_done;
  assign s0_axil_bvalid  = in_resp && grant_q[0] && m_axil_bvalid;
  assign s1_axil_bvalid  = in_resp && grant_q[1] && m_axil_bvalid;
  assign s0_axil_bresp   = (in_resp && grant_q[0]) ? m_axil_bresp : 2'b00;
  assign s1_axil_bresp   = (in_resp && grant_q[1]) ? m_axil_bresp : 2'b00;

  assign aw_fire = m_axil_awvalid && m_axil_awready;
  assign w_fire  = m_axil_wvalid && m_axil_wready;
  assign b_fire  = m_axil_bvalid && m_axil_bready;

  assign grant = grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick != 2'b00) begin
            grant_q <= pick;
            state   <= S_XFER;
          end
        end
        S_XFER: begin
          // AW and W may complete in the same or in different cycles.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            state   <= S_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_done || aw_fire;
            w_done  <= w_done || w_fire;
          end
        end
        S_RESP: begin
          if (b_fire) begin
            state   <= S_IDLE;
            grant_q <= 2'b00;
            last_q  <= sel;
          end
        end
        default: begin
          state   <= S_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_wr_arb2.sv
// Self-checking bench for axil_wr_arb2: vector table plus master scoreboard.
// Drives both slave ports and models the downstream register bridge.
module tb_axil_wr_arb2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [1:0]       s_awvalid, s_wvalid, s_bready;
  logic [1:0]       s_awready, s_wready, s_bvalid;
  logic [1:0][31:0] s_awaddr;
  logic [1:0][2:0]  s_awprot;
  logic [1:0][31:0] s_wdata;
  logic [1:0][3:0]  s_wstrb;
  logic [1:0][1:0]  s_bresp;

  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic [1:0]  grant;

  axil_wr_arb2 dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s0_axil_awaddr  (s_awaddr[0]),
    .s0_axil_awprot  (s_awprot[0]),
    .s0_axil_awvalid (s_awvalid[0]),
    .s0_axil_awready (s_awready[0]),
    .s0_axil_wdata   (s_wdata[0]),
    .s0_axil_wstrb   (s_wstrb[0]),
    .s0_axil_wvalid  (s_wvalid[0]),
    .s0_axil_wready  (s_wready[0]),
    .s0_axil_bresp   (s_bresp[0]),
    .s0_axil_bvalid  (s_bvalid[0]),
    .s0_axil_bready  (s_bready[0]),
    .s1_axil_awaddr  (s_awaddr[1]),
    .s1_axil_awprot  (s_awprot[1]),
    .s1_axil_awvalid (s_awvalid[1]),
    .s1_axil_awready (s_awready[1]),
    .s1_axil_wdata   (s_wdata[1]),
    .s1_axil_wstrb   (s_wstrb[1]),
    .s1_axil_wvalid  (s_wvalid[1]),
    .s1_axil_wready  (s_wready[1]),
    .s1_axil_bresp   (s_bresp[1]),
    .s1_axil_bvalid  (s_bvalid[1]),
    .s1_axil_bready  (s_bready[1]),
    .m_axil_awaddr   (m_awaddr),
    .m_axil_awprot   (m_awprot),
    .m_axil_awvalid  (m_awvalid),
    .m_axil_awready  (m_awready),
    .m_axil_wdata    (m_wdata),
    .m_axil_wstrb    (m_wstrb),
    .m_axil_wvalid   (m_wvalid),
    .m_axil_wready   (m_wready),
    .m_axil_bresp    (m_bresp),
    .m_axil_bvalid   (m_bvalid),
    .m_axil_bready   (m_bready),
    .grant           (grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        p;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } exp_t;

  exp_t exp_q[$];
  bit   aw_seen = 1'b0;
  bit   w_seen  = 1'b0;

  // Master-side scoreboard: handshakes seen here complete on the next edge.
  always @(negedge clk) begin
    if (m_awvalid && m_awready) begin
      chk("aw_extra", 64'(aw_seen || exp_q.size() == 0), 64'(0));
      if (!aw_seen && exp_q.size() != 0) begin
        chk("aw_addr", 64'(m_awaddr), 64'(exp_q[0].addr));
        chk("aw_prot", 64'(m_awprot), 64'(exp_q[0].prot));
        chk("aw_grant", 64'(grant), exp_q[0].p ? 64'(2) : 64'(1));
        aw_seen = 1'b1;
      end
    end
    if (m_wvalid && m_wready) begin
      chk("w_extra", 64'(w_seen || exp_q.size() == 0), 64'(0));
      if (!w_seen && exp_q.size() != 0) begin
        chk("w_data", 64'(m_wdata), 64'(exp_q[0].data));
        chk("w_strb", 64'(m_wstrb), 64'(exp_q[0].strb));
        w_seen = 1'b1;
      end
    end
    if (aw_seen && w_seen) begin
      void'(exp_q.pop_front());
      aw_seen = 1'b0;
      w_seen  = 1'b0;
    end
  end

  typedef struct {
    int          p;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    bit          other;
    bit          keep;
    bit          pre_rst;
    int          lag;
    int          hold;
    int          bcyc;
    logic [1:0]  gnt;
  } vec_t;

  function automatic vec_t mk(int p, logic [31:0] a, logic [31:0] d,
                              logic [3:0] s, logic [1:0] r, bit o,
                              bit k, bit pr, int lag, int hold,
                              int bc, logic [1:0] g);
    vec_t v;
    v.p = p; v.addr = a; v.data = d; v.strb = s; v.resp = r;
    v.other = o; v.keep = k; v.pre_rst = pr; v.lag = lag;
    v.hold = hold; v.bcyc = bc; v.gnt = g;
    return v;
  endfunction

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    int np;
    bit done, aw_ok, w_ok, awh, wh, bh;
    int gcnt, hcnt;
    exp_t e;
    np = 1 - v.p;
    done = 0; aw_ok = 0; w_ok = 0; gcnt = 0; hcnt = 0;
    s_awaddr[v.p]  = v.addr;
    s_awprot[v.p]  = (v.p == 1) ? 3'b010 : 3'b001;
    s_wdata[v.p]   = v.data;
    s_wstrb[v.p]   = v.strb;
    s_awvalid[v.p] = 1'b1;
    s_wvalid[v.p]  = 1'b1;
    s_bready[v.p]  = (v.hold == 0);
    if (v.other) begin
      s_awvalid[np] = 1'b1;
      s_wvalid[np]  = 1'b1;
    end
    m_awready = 1'b1;
    m_wready  = (v.lag == 0);
    m_bvalid  = 1'b0;
    e.p = v.p[0]; e.addr = v.addr; e.data = v.data;
    e.strb = v.strb; e.prot = s_awprot[v.p];
    exp_q.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("idle_grant", 64'(grant), 64'(0));
        chk("idle_valids", 64'({m_awvalid, m_wvalid, m_bready}), 64'(0));
        chk("idle_payload", 64'({m_awaddr, m_wdata}), 64'(0));
      end else begin
        chk("grant", 64'(grant), 64'(v.gnt));
      end
      chk("other_quiet", 64'({s_awready[np], s_wready[np],
                              s_bvalid[np], s_bresp[np]}), 64'(0));
      if (aw_ok) chk("awvalid_dropped", 64'(m_awvalid), 64'(0));
      if (c >= 1 && !w_ok && s_wvalid[v.p])
        chk("wvalid_held", 64'(m_wvalid), 64'(1));
      if (s_bvalid[v.p]) chk("bresp", 64'(s_bresp[v.p]), 64'(v.resp));
      if (s_bvalid[v.p] && !s_bready[v.p])
        chk("bready_hold", 64'(m_bready), 64'(0));
      awh = s_awvalid[v.p] && s_awready[v.p];
      wh  = s_wvalid[v.p] && s_wready[v.p];
      bh  = s_bvalid[v.p] && s_bready[v.p];
      if (m_awvalid && m_awready) aw_ok = 1;
      if (m_wvalid && m_wready) w_ok = 1;
      if (grant != 2'b00) gcnt++;
      if (s_bvalid[v.p]) hcnt++;
      if (bh) begin
        chk("b_cycle", 64'(c), 64'(v.bcyc));
        done = 1;
      end
      @(posedge clk); #1;
      if (awh) s_awvalid[v.p] = 1'b0;
      if (wh) s_wvalid[v.p] = 1'b0;
      if (gcnt >= v.lag) m_wready = 1'b1;
      if (hcnt >= v.hold) s_bready[v.p] = 1'b1;
      if (aw_ok && w_ok && !bh) begin
        m_bvalid = 1'b1;
        m_bresp  = v.resp;
      end
      if (bh) begin
        m_bvalid = 1'b0;
        s_bready[v.p] = 1'b0;
        if (v.keep) begin
          s_awvalid[v.p] = 1'b1;
          s_wvalid[v.p]  = 1'b1;
        end
      end
    end
    chk("txn_done", 64'(done), 64'(1));
  endtask

  // Abandon a stalled XFER with an asynchronous reset.
  task automatic reset_mid_xfer();
    m_awready = 1'b0;
    m_wready  = 1'b0;
    s_awaddr[0] = 32'h50; s_wdata[0] = 32'h5050_5050;
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_bready[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_grant", 64'(grant), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_m_valids", 64'({m_awvalid, m_wvalid, m_bready}), 64'(0));
    chk("rst_s_ready", 64'({s_awready, s_wready, s_bvalid}), 64'(0));
    chk("rst_payload", 64'({m_awaddr, m_wdata}), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_no_b", 64'(s_bvalid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_awvalid = 2'b00; s_wvalid = 2'b00; s_bready = 2'b00;
    m_awready = 1'b1;
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = mk(0, 32'h10,  32'hA5A5A5A5, 4'hF, 2'b00, 0, 0, 0, 0, 0, 2, 2'b01);
    tbl[1]  = mk(1, 32'hFFC, 32'h12345678, 4'hF, 2'b10, 0, 0, 0, 0, 0, 2, 2'b10);
    tbl[2]  = mk(0, 32'h20,  32'h11111111, 4'h1, 2'b00, 1, 1, 0, 0, 0, 2, 2'b01);
    tbl[3]  = mk(1, 32'h24,  32'h22222222, 4'h3, 2'b01, 1, 1, 0, 0, 0, 2, 2'b10);
    tbl[4]  = mk(0, 32'h28,  32'h33333333, 4'hC, 2'b11, 1, 1, 0, 0, 0, 2, 2'b01);
    tbl[5]  = mk(1, 32'h2C,  32'h44444444, 4'hF, 2'b00, 1, 0, 0, 0, 0, 2, 2'b10);
    tbl[6]  = mk(0, 32'h30,  32'h55AA55AA, 4'hF, 2'b00, 0, 0, 0, 1, 0, 3, 2'b01);
    tbl[7]  = mk(1, 32'h34,  32'hDEADBEEF, 4'hF, 2'b10, 1, 0, 0, 0, 5, 7, 2'b10);
    tbl[8]  = mk(0, 32'h38,  32'h0BADF00D, 4'h5, 2'b00, 0, 0, 0, 0, 0, 2, 2'b01);
    tbl[9]  = mk(0, 32'h40,  32'hCAFEBABE, 4'hF, 2'b00, 1, 0, 1, 0, 0, 2, 2'b01);
    tbl[10] = mk(1, 32'h44,  32'h87654321, 4'hA, 2'b00, 0, 0, 0, 0, 0, 2, 2'b10);

    rst_n = 1'b0;
    s_awaddr = '0; s_awprot = '0; s_wdata = '0; s_wstrb = '0;
    s_awvalid = 2'b01; s_wvalid = 2'b01; s_bready = 2'b11;
    m_awready = 1'b1; m_wready = 1'b1;
    m_bvalid = 1'b0; m_bresp = 2'b00;

    @(negedge clk);
    chk("reset_grant", 64'(grant), 64'(0));
    chk("reset_m_valids", 64'({m_awvalid, m_wvalid, m_bready}), 64'(0));
    chk("reset_s_ready", 64'({s_awready, s_wready, s_bvalid}), 64'(0));
    chk("reset_payload", 64'({m_awaddr, m_wdata}), 64'(0));
    @(posedge clk); #1;
    s_awvalid = 2'b00; s_wvalid = 2'b00; s_bready = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].pre_rst) reset_mid_xfer();
      run_vec(tbl[i]);
    end

    @(negedge clk);
    chk("final_grant", 64'(grant), 64'(0));
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
